// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: masked receive FIFO with show-ahead read, RTS hysteresis and interrupts.
// Optional character timeout built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH         = 16,
  parameter int RTS_HI        = 14,
  parameter int RTS_LO        = 8,
  parameter int TIMEOUT_TICKS = 640,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_tick,
  input  logic [1:0]    data_bit_num_i,
  input  logic          rx_en_i,
  input  logic          rx_done_i,
  input  logic [31:0]   rx_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o,
  input  logic [AW:0]   irq_thresh_i,
  input  logic          ovr_clr_i,
  output logic          overrun_o,
  output logic          timeout_o,
  output logic          irq_o,
  output logic          rts_n
);
  typedef enum logic {ACCEPT, THROTTLE} rts_t;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level, w_level_nxt;
  logic          r_ovr;
  rts_t          r_rts, w_rts_nxt;
  logic          w_empty, w_full, w_push_req, w_pop, w_push, w_ovr_set;
  logic [7:0]    w_mask;
  logic          w_unused;
  assign w_unused    = ^{rx_data_i[31:8], rx_tick};
  assign w_empty     = r_level == '0;
  assign w_full      = r_level == (AW+1)'(DEPTH);
  assign w_push_req  = rx_done_i & rx_en_i;
  assign w_pop       = rd_en_i & !w_empty;
  // a full FIFO still accepts a push when the same cycle frees a slot
  assign w_push      = w_push_req & (!w_full | w_pop);
  assign w_ovr_set   = w_push_req & w_full & !w_pop;
  assign w_mask      = 8'hFF >> (2'd3 - data_bit_num_i);
  assign w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= rx_data_i[7:0] & w_mask;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= w_level_nxt;
      r_ovr   <= w_ovr_set | (r_ovr & !ovr_clr_i);
    end
  end
  always_ff @(posedge clk) r_rts <= rst ? THROTTLE : w_rts_nxt;
  always_comb begin
    w_rts_nxt = r_rts;
    w_rts_nxt = (r_rts == ACCEPT)
      ? ((r_level >= (AW+1)'(RTS_HI) || !rx_en_i) ? THROTTLE : ACCEPT)
      : ((r_level <= (AW+1)'(RTS_LO) && rx_en_i) ? ACCEPT : THROTTLE);
  end
`ifdef UART_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_TICKS);
  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXPIRED} tmo_t;
  tmo_t          r_tst, w_tst_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tst <= T_IDLE;
      r_cnt <= '0;
    end else begin
      r_tst <= w_tst_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  always_comb begin
    w_tst_nxt = r_tst;
    w_cnt_nxt = '0;
    if (w_level_nxt == '0) w_tst_nxt = T_IDLE;
    else if (r_tst == T_IDLE || w_push || w_pop) w_tst_nxt = T_COUNT;
    else if (r_tst == T_COUNT && rx_tick) begin
      w_tst_nxt = (r_cnt == CW'(TIMEOUT_TICKS - 1)) ? T_EXPIRED : T_COUNT;
      w_cnt_nxt = r_cnt + 1'b1;
    end else w_cnt_nxt = r_cnt;
  end
  assign timeout_o = r_tst == T_EXPIRED;
`else
  assign timeout_o = 1'b0;
`endif
  assign rd_data_o = w_empty ? 8'h00 : r_mem[r_rp];
  assign empty_o   = w_empty;
  assign full_o    = w_full;
  assign level_o   = r_level;
  assign overrun_o = r_ovr;
  assign rts_n     = r_rts == THROTTLE;
  assign irq_o     = ((irq_thresh_i != '0) && (r_level >= irq_thresh_i)) | r_ovr | timeout_o;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb_uart_rx_fifo_ctrl: directed self-checking bench for uart_rx_fifo_ctrl (DEPTH=16, RTS 14/8).
module tb_uart_rx_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst, rx_tick, rx_en_i, rx_done_i, rd_en_i, ovr_clr_i;
  logic [1:0]  data_bit_num_i;
  logic [31:0] rx_data_i;
  logic [4:0]  irq_thresh_i, level_o;
  logic [7:0]  rd_data_o;
  logic        empty_o, full_o, overrun_o, timeout_o, irq_o, rts_n;
  int          n_chk = 0;
  int          n_fail = 0;
  uart_rx_fifo_ctrl dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .data_bit_num_i(data_bit_num_i),
    .rx_en_i(rx_en_i), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o), .level_o(level_o),
    .irq_thresh_i(irq_thresh_i), .ovr_clr_i(ovr_clr_i), .overrun_o(overrun_o),
    .timeout_o(timeout_o), .irq_o(irq_o), .rts_n(rts_n)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] d);
    rx_data_i = d;
    rx_done_i = 1'b1;
    step();
    rx_done_i = 1'b0;
  endtask
  task automatic pop();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rx_tick = 1'b0; rx_en_i = 1'b1; rx_done_i = 1'b0; rd_en_i = 1'b0;
    ovr_clr_i = 1'b0; data_bit_num_i = 2'b11; rx_data_i = '0; irq_thresh_i = '0;
    step(); step();
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_tmo", timeout_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_rts", rts_n, 1);
    chk("rst_rdata", rd_data_o, 0);
    rst = 1'b0;
    step();
    chk("rts_after_rst", rts_n, 0);
    push(32'hA5);
    chk("push_rdata", rd_data_o, 8'hA5);
    chk("push_level", level_o, 1);
    chk("push_empty", empty_o, 0);
    pop();
    chk("pop_empty", empty_o, 1);
    chk("pop_level", level_o, 0);
    data_bit_num_i = 2'b00;
    push(32'h0000_00FF);
    chk("mask5", rd_data_o, 8'h1F);
    data_bit_num_i = 2'b01;
    push(32'hFFFF_FFFF);
    pop();
    chk("mask6", rd_data_o, 8'h3F);
    pop();
    data_bit_num_i = 2'b11;
    pop();
    chk("pop_empty_level", level_o, 0);
    chk("pop_empty_empty", empty_o, 1);
    rx_en_i = 1'b0;
    push(32'h55);
    chk("dis_level", level_o, 0);
    chk("dis_ovr", overrun_o, 0);
    chk("dis_rts", rts_n, 1);
    rx_en_i = 1'b1;
    step();
    chk("en_rts", rts_n, 0);
    for (int i = 0; i < 13; i++) push(32'h10 + i);
    step();
    chk("lvl13_rts", rts_n, 0);
    push(32'h1D);
    step();
    chk("lvl14_level", level_o, 14);
    chk("lvl14_rts", rts_n, 1);
    irq_thresh_i = 5'd14;
    #1 chk("irq_thresh_hit", irq_o, 1);
    irq_thresh_i = 5'd15;
    #1 chk("irq_thresh_miss", irq_o, 0);
    irq_thresh_i = 5'd0;
    #1 chk("irq_thresh_off", irq_o, 0);
    push(32'h1E);
    push(32'h1F);
    chk("full_level", level_o, 16);
    chk("full_flag", full_o, 1);
    chk("full_no_ovr", overrun_o, 0);
    push(32'h77);
    chk("ovr_set", overrun_o, 1);
    chk("ovr_level", level_o, 16);
    chk("ovr_irq", irq_o, 1);
    chk("ovr_head", rd_data_o, 8'h10);
    ovr_clr_i = 1'b1;
    step();
    ovr_clr_i = 1'b0;
    chk("ovr_clr", overrun_o, 0);
    rx_data_i = 32'h99; rx_done_i = 1'b1; rd_en_i = 1'b1;
    step();
    rx_done_i = 1'b0; rd_en_i = 1'b0;
    chk("pp_level", level_o, 16);
    chk("pp_ovr", overrun_o, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("order%0d", k), rd_data_o, (k < 15) ? 32'h11 + k : 32'h99);
      pop();
      if (level_o == 9) begin
        step();
        chk("lvl9_rts", rts_n, 1);
      end
      if (level_o == 8) begin
        step();
        chk("lvl8_rts", rts_n, 0);
      end
    end
    chk("drain_empty", empty_o, 1);
    for (int i = 0; i < 16; i++) push(32'h20 + i);
    ovr_clr_i = 1'b1;
    push(32'h88);
    ovr_clr_i = 1'b0;
    chk("ovr_set_wins", overrun_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_level", level_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    chk("mid_rst_ovr", overrun_o, 0);
    chk("mid_rst_rts", rts_n, 1);
    push(32'h42);
    step();
    rx_tick = 1'b1;
    for (int i = 0; i < 639; i++) step();
`ifdef UART_RX_TIMEOUT_EN
    chk("tmo_639", timeout_o, 0);
    step();
    rx_tick = 1'b0;
    chk("tmo_640", timeout_o, 1);
    chk("tmo_irq", irq_o, 1);
    pop();
    chk("tmo_pop", timeout_o, 0);
`else
    for (int i = 0; i < 60; i++) step();
    rx_tick = 1'b0;
    chk("tmo_off", timeout_o, 0);
    chk("tmo_off_irq", irq_o, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side buffer and flow controller between `uart_rx` and the APB register block. Captures each completed character from `uart_rx`, masks it to the configured data width and queues it in a FIFO. The register block drains the FIFO with a show-ahead read port. The block drives `rts_n` with hysteresis and raises level, overrun and (optional) character-timeout interrupts.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 4. `AW = $clog2(DEPTH)`.
- `RTS_HI`, 14: level at or above which `rts_n` deasserts.
- `RTS_LO`, 8: level at or below which `rts_n` reasserts. Must satisfy `RTS_LO < RTS_HI <= DEPTH`.
- `TIMEOUT_TICKS`, 640: `rx_tick` count for character timeout.

Ports:
- `clk`, in, 1: single clock. Everything is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_tick`, in, 1: baud oversample tick from the baudrate generator.
- `data_bit_num_i`, in, 2: character width. 00=5, 01=6, 10=7, 11=8 bits.
- `rx_en_i`, in, 1: receiver enable.
- `rx_done_i`, in, 1: one-cycle pulse from `uart_rx`; character valid.
- `rx_data_i`, in, 32: character from `uart_rx`. Only bits [7:0] are used.
- `rd_en_i`, in, 1: pop request from the register block.
- `rd_data_o`, out, 8: head entry (show-ahead).
- `empty_o`, out, 1: FIFO empty.
- `full_o`, out, 1: FIFO full.
- `level_o`, out, AW+1: number of stored entries.
- `irq_thresh_i`, in, AW+1: level interrupt threshold. 0 disables the level interrupt.
- `ovr_clr_i`, in, 1: clears the overrun flag.
- `overrun_o`, out, 1: sticky overrun flag.
- `timeout_o`, out, 1: character timeout flag.
- `irq_o`, out, 1: combined interrupt.
- `rts_n`, out, 1: request-to-send, active low.

## Operation

Reset values:
- `rts_n`: 1.
- `level_o`, `full_o`, `overrun_o`, `timeout_o`, `irq_o`: 0.
- `empty_o`: 1.
- `rd_data_o`: 0.
- Pointers: 0.

Push:
- Occurs when `rx_done_i && rx_en_i`.
- Stored byte is `rx_data_i[7:0]` with bits at positions at or above the configured width forced to 0.
- Push while full and no pop: the data is dropped, `overrun_o` is set and stored contents are unchanged.
- `rx_done_i` while `!rx_en_i`: ignored, with no overrun.

Pop:
- `rd_en_i && !empty_o` advances the read pointer.
- `rd_en_i` while empty is ignored. Pointers and flags are unchanged.

Simultaneous push and pop:
- Both take effect and `level_o` is unchanged.
- When full, the push is accepted and no overrun is raised.
- When empty, only the push takes effect.

Pointers wrap modulo `DEPTH`. `level_o` reaches `DEPTH` exactly when full.

`overrun_o` clears on `ovr_clr_i`. If a new overrun occurs in the same cycle as `ovr_clr_i`, set wins.

RTS FSM (`ACCEPT`, `THROTTLE`), evaluated on post-update level:
- `ACCEPT` → `THROTTLE` when `level >= RTS_HI` or `!rx_en_i`.
- `THROTTLE` → `ACCEPT` when `level <= RTS_LO` and `rx_en_i`.
- `rts_n` is 1 in `THROTTLE`, 0 in `ACCEPT`.
- Reset enters `THROTTLE`.

`irq_o = ((irq_thresh_i != 0) && level_o >= irq_thresh_i) | overrun_o | timeout_o`

## Timing

- Push → entry visible on `rd_data_o`, `level_o` and `empty_o` on the cycle after `rx_done_i`.
- Pop → `rd_data_o` shows the next entry on the cycle after `rd_en_i`.
- `rts_n` is registered: it changes one cycle after the level crossing.
  - After reset with `rx_en_i=1`: `rts_n` drops to 0 one cycle after `rst` falls.
- `irq_o` is combinational from registered state, so it has the same-cycle relation to `level_o`, `overrun_o` and `timeout_o`.
- Reset mid-operation: contents are discarded, all outputs take their reset values on the next edge, and pending pulses are lost.

## Configuration

Macro `UART_RX_TIMEOUT_EN`.

Defined: timeout FSM (`T_IDLE`, `T_COUNT`, `T_EXPIRED`) with a counter of `$clog2(TIMEOUT_TICKS)` bits.
- `T_IDLE` → `T_COUNT` when FIFO is non-empty.
- In `T_COUNT`, the counter increments on `rx_tick`.
- Any push or pop restarts the counter at 0 in `T_COUNT`.
- Becoming empty → `T_IDLE` with counter 0.
- Tick at count `TIMEOUT_TICKS-1` → `T_EXPIRED`.
- `timeout_o` = 1 only in `T_EXPIRED`.
- `T_EXPIRED` exits on push or pop: to `T_COUNT` if still non-empty, otherwise to `T_IDLE`.

Undefined: no counter or FSM logic; `timeout_o` is tied to 0.

## Test plan

- Reset, `rx_en_i=1`, push 0xA5 with `data_bit_num_i=11` → next cycle `rd_data_o=0xA5`, `level_o=1`, `empty_o=0`. Pop → `empty_o=1`.
- `data_bit_num_i=00`, push `rx_data_i=0x000000FF` → `rd_data_o=0x1F`.
- 17 pushes with `DEPTH=16` and no pops → `full_o=1`, `overrun_o=1`, and entry 16 preserved. `ovr_clr_i` → `overrun_o=0`.
- Fill to level 14 → `rts_n=1` one cycle later. Pop to level 9 → `rts_n` stays 1. Pop to level 8 → `rts_n=0`.
- Full FIFO, push and pop in the same cycle → `level_o=16`, `overrun_o=0`, and the new byte is last in pop order.
- With `UART_RX_TIMEOUT_EN`, one entry and 640 `rx_tick` pulses with no push or pop → `timeout_o=1` and `irq_o=1`. Pop → `timeout_o=0`.
